// File: rtl/bounded_step_updown_counter.sv
// Up/down counter that moves by a variable step between two runtime bounds.
// Crossing a bound either saturates or wraps to the opposite bound, and raises a one-cycle flag.
module bounded_step_updown_counter #(
  parameter int               WIDTH       = 8,
  parameter int               STEP_WIDTH  = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [WIDTH-1:0]      lo_bound,
  input  logic [WIDTH-1:0]      hi_bound,
  input  logic                  sat_mode,
  output logic [WIDTH-1:0]      count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  sticky_event,
  output logic                  at_max,
  output logic                  at_min,
  output logic                  cfg_err
);

  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   lo_plus_step;
  logic [WIDTH-1:0] down_diff;
  logic             up_over;
  logic             down_under;

  logic [WIDTH-1:0] count_next;
  logic             overflow_next;
  logic             underflow_next;
  logic             sticky_next;

  assign at_max  = (count == hi_bound);
  assign at_min  = (count == lo_bound);
  assign cfg_err = (lo_bound > hi_bound);

  // One extra bit keeps the bound tests exact near the top and bottom of the range.
  always_comb begin
    step_ext     = {{(WIDTH + 1 - STEP_WIDTH){1'b0}}, step};
    up_sum       = {1'b0, count} + step_ext;
    lo_plus_step = {1'b0, lo_bound} + step_ext;
    down_diff    = count - step_ext[WIDTH-1:0];
    up_over      = (up_sum > {1'b0, hi_bound});
    down_under   = ({1'b0, count} < lo_plus_step);
  end

  always_comb begin
    count_next     = count;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    sticky_next    = sticky_event;

    if (clear) begin
      count_next  = lo_bound;
      sticky_next = 1'b0;
    end else if (load) begin
      count_next = load_value;
    end else if (enable && !cfg_err) begin
      if (up_down) begin
        if (up_over) begin
          overflow_next = 1'b1;
          sticky_next   = 1'b1;
          count_next    = sat_mode ? hi_bound : lo_bound;
        end else begin
          count_next = up_sum[WIDTH-1:0];
        end
      end else begin
        if (down_under) begin
          underflow_next = 1'b1;
          sticky_next    = 1'b1;
          count_next     = sat_mode ? lo_bound : hi_bound;
        end else begin
          count_next = down_diff;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= RESET_VALUE;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      sticky_event <= 1'b0;
    end else begin
      count        <= count_next;
      overflow     <= overflow_next;
      underflow    <= underflow_next;
      sticky_event <= sticky_next;
    end
  end

endmodule

// File: tb/tb_bounded_step_updown_counter.sv
// Directed-vector bench: each vector queues its expected post-edge state; a monitor
// compares the registered and combinational outputs on the following falling edge.
module tb_bounded_step_updown_counter;

  localparam int               WIDTH      = 8;
  localparam int               STEP_WIDTH = 4;
  localparam logic [WIDTH-1:0] RST_VAL    = 8'd7;

  logic                  clk;
  logic                  rst_n;
  logic                  clear;
  logic                  load;
  logic [WIDTH-1:0]      load_value;
  logic                  enable;
  logic                  up_down;
  logic [STEP_WIDTH-1:0] step;
  logic [WIDTH-1:0]      lo_bound;
  logic [WIDTH-1:0]      hi_bound;
  logic                  sat_mode;
  logic [WIDTH-1:0]      count;
  logic                  overflow;
  logic                  underflow;
  logic                  sticky_event;
  logic                  at_max;
  logic                  at_min;
  logic                  cfg_err;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] count;
    logic             ovf;
    logic             unf;
    logic             sticky;
    logic             at_max;
    logic             at_min;
    logic             cfg_err;
  } expect_t;

  expect_t exp_q[$];
  int      total = 0;
  int      bad   = 0;

  bounded_step_updown_counter #(
    .WIDTH(WIDTH),
    .STEP_WIDTH(STEP_WIDTH),
    .RESET_VALUE(RST_VAL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .load(load),
    .load_value(load_value),
    .enable(enable),
    .up_down(up_down),
    .step(step),
    .lo_bound(lo_bound),
    .hi_bound(hi_bound),
    .sat_mode(sat_mode),
    .count(count),
    .overflow(overflow),
    .underflow(underflow),
    .sticky_event(sticky_event),
    .at_max(at_max),
    .at_min(at_min),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input expect_t e);
    total++;
    if (count !== e.count || overflow !== e.ovf || underflow !== e.unf ||
        sticky_event !== e.sticky || at_max !== e.at_max || at_min !== e.at_min ||
        cfg_err !== e.cfg_err) begin
      bad++;
      $display("[TB] FAIL %s: got count=%0d ovf=%b unf=%b sticky=%b max=%b min=%b cfg=%b, want count=%0d ovf=%b unf=%b sticky=%b max=%b min=%b cfg=%b",
               e.name, count, overflow, underflow, sticky_event, at_max, at_min, cfg_err,
               e.count, e.ovf, e.unf, e.sticky, e.at_max, e.at_min, e.cfg_err);
    end
  endtask

  // Inputs change only just after a falling edge, so they are stable at both the edge and the check.
  task automatic apply_stimulus(
    input string name,
    input logic clr, input logic ld, input logic [WIDTH-1:0] lv,
    input logic en, input logic up, input logic [STEP_WIDTH-1:0] st,
    input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi, input logic sat,
    input logic [WIDTH-1:0] e_count, input logic e_ovf, input logic e_unf, input logic e_sticky
  );
    expect_t e;
    clear      = clr;
    load       = ld;
    load_value = lv;
    enable     = en;
    up_down    = up;
    step       = st;
    lo_bound   = lo;
    hi_bound   = hi;
    sat_mode   = sat;
    @(posedge clk);
    e.name    = name;
    e.count   = e_count;
    e.ovf     = e_ovf;
    e.unf     = e_unf;
    e.sticky  = e_sticky;
    e.at_max  = (e_count == hi);
    e.at_min  = (e_count == lo);
    e.cfg_err = (lo > hi);
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check_output(exp_q.pop_front());
  end

  initial begin
    expect_t e;
    rst_n = 1'b0;
    //              name            clr ld lv    en up st  lo  hi   sat  count ovf unf stk
    apply_stimulus("reset_hold",    0, 0, 8'd0,  1, 1, 1, 10, 20,  0,   7,    0,  0,  0);
    rst_n = 1'b1;
    apply_stimulus("release_idle",  0, 0, 8'd0,  0, 1, 1, 10, 20,  0,   7,    0,  0,  0);
    apply_stimulus("load_18",       0, 1, 8'd18, 0, 1, 0, 10, 20,  0,  18,    0,  0,  0);
    apply_stimulus("wrap_up_ovf",   0, 0, 8'd0,  1, 1, 3, 10, 20,  0,  10,    1,  0,  1);
    apply_stimulus("hold_pulse_off",0, 0, 8'd0,  0, 1, 3, 10, 20,  0,  10,    0,  0,  1);
    apply_stimulus("up_4",          0, 0, 8'd0,  1, 1, 4, 10, 20,  0,  14,    0,  0,  1);
    apply_stimulus("down_2",        0, 0, 8'd0,  1, 0, 2, 10, 20,  0,  12,    0,  0,  1);
    apply_stimulus("sat_down_unf",  0, 0, 8'd0,  1, 0, 4, 10, 20,  1,  10,    0,  1,  1);
    apply_stimulus("sat_down_again",0, 0, 8'd0,  1, 0, 4, 10, 20,  1,  10,    0,  1,  1);
    apply_stimulus("step_zero",     0, 0, 8'd0,  1, 1, 0, 10, 20,  1,  10,    0,  0,  1);
    apply_stimulus("sat_up_ovf",    0, 0, 8'd0,  1, 1, 15,10, 20,  1,  20,    1,  0,  1);
    apply_stimulus("sat_up_at_hi",  0, 0, 8'd0,  1, 1, 1, 10, 20,  1,  20,    1,  0,  1);
    apply_stimulus("clr_ld_en",     1, 1, 8'd50, 1, 1, 1, 10, 20,  0,  10,    0,  0,  0);
    apply_stimulus("load_200",      0, 1, 8'd200,0, 1, 1, 10, 20,  0, 200,    0,  0,  0);
    apply_stimulus("above_hi_up",   0, 0, 8'd0,  1, 1, 1, 10, 20,  0,  10,    1,  0,  1);
    apply_stimulus("wrap_down_unf", 0, 0, 8'd0,  1, 0, 1, 10, 20,  0,  20,    0,  1,  1);
    apply_stimulus("down_step0",    0, 0, 8'd0,  1, 0, 0, 10, 20,  0,  20,    0,  0,  1);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus("cfg_err_hold",0, 0, 8'd0, (i % 2 == 0), 1, 5, 30, 20, 0, 20, 0, 0, 1);
    end
    apply_stimulus("eq_bounds_up",  0, 0, 8'd0,  1, 1, 2, 15, 15,  1,  15,    1,  0,  1);
    apply_stimulus("eq_bounds_down",0, 0, 8'd0,  1, 0, 1, 15, 15,  0,  15,    0,  1,  1);
    apply_stimulus("bound_change",  0, 0, 8'd0,  0, 0, 1,  0,255,  0,  15,    0,  0,  1);
    apply_stimulus("down_to_zero",  0, 0, 8'd0,  1, 0, 15, 0,255,  0,   0,    0,  0,  1);
    apply_stimulus("wrap_from_0",   0, 0, 8'd0,  1, 0, 1,  0,255,  0, 255,    0,  1,  1);
    apply_stimulus("carry_top",     0, 0, 8'd0,  1, 1, 1,  0,255,  0,   0,    1,  0,  1);
    apply_stimulus("load_18_b",     0, 1, 8'd18, 0, 1, 3, 15, 20,  0,  18,    0,  0,  1);
    apply_stimulus("ovf_to_15",     0, 0, 8'd0,  1, 1, 3, 15, 20,  0,  15,    1,  0,  1);

    // Asynchronous reset while overflow is high, checked before the next rising edge.
    enable = 1'b0;
    rst_n  = 1'b0;
    #1;
    e.name    = "async_reset";
    e.count   = RST_VAL;
    e.ovf     = 1'b0;
    e.unf     = 1'b0;
    e.sticky  = 1'b0;
    e.at_max  = 1'b0;
    e.at_min  = 1'b0;
    e.cfg_err = 1'b0;
    check_output(e);
    #1;
    rst_n = 1'b1;
    apply_stimulus("post_reset",    0, 0, 8'd0,  0, 1, 4, 15, 20,  0,   7,    0,  0,  0);
    apply_stimulus("up_below_lo",   0, 0, 8'd0,  1, 1, 4, 15, 20,  0,  11,    0,  0,  0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending checks, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
